// File: rtl/vga_pkg.sv
// Shared VGA definitions: RGB332 layout, named colours, sync idle levels.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: none; video timing is free-running.
package vga_pkg;

    // RGB332 field widths and bit positions
    localparam int RGB_W   = 8;
    localparam int RED_W   = 3;
    localparam int GRN_W   = 3;
    localparam int BLU_W   = 2;
    localparam int RED_LSB = 5;
    localparam int GRN_LSB = 2;
    localparam int BLU_LSB = 0;

    typedef struct packed {
        logic [RED_W-1:0] r;
        logic [GRN_W-1:0] g;
        logic [BLU_W-1:0] b;
    } rgb332_t;

    // Named colours used by the pixel sources and the compositor
    localparam rgb332_t COLOR_BLANK = 8'b000_000_00;
    localparam rgb332_t COLOR_BG    = 8'b010_010_01;
    localparam rgb332_t COLOR_SNAKE = 8'b000_111_00;
    localparam rgb332_t COLOR_COIN  = 8'b111_111_00;
    localparam rgb332_t COLOR_BOX   = 8'b111_000_00;

    // Syncs are active low, so the idle level is 1
    localparam logic HSYNC_IDLE = 1'b1;
    localparam logic VSYNC_IDLE = 1'b1;

    typedef struct packed {
        logic hs;
        logic vs;
        logic von;
    } sync_t;

    localparam sync_t SYNC_RESET = '{hs: HSYNC_IDLE, vs: VSYNC_IDLE, von: 1'b0};

    // Expand RGB332 to the 3/3/3 pin format; blue LSB is tied low
    function automatic logic [8:0] rgb332_to_pins(input rgb332_t c);
        return {c.r, c.g, c.b, 1'b0};
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Parametrised shift register used to delay-match sync/video-on to layer latency.
// Latency: DEPTH cycles (DEPTH=0 is a plain wire).
// Backpressure: none; shifts every cycle.
module vga_delay_line #(
    parameter int                WIDTH     = 1,
    parameter int                DEPTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    generate
        if (DEPTH == 0) begin : g_wire
            // No storage: clock and reset are intentionally unused here
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = i_clk ^ i_reset;
            assign o_dat = i_dat;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            // Shift the input through DEPTH stages; reset loads the idle value
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RESET_VAL;
                    end
                end else begin
                    r_stage[0] <= i_dat;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_dat = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_layer_compositor.sv
// Priority-merges NUM_LAYERS RGB332 sources over a background, delay-matches syncs, counts frames.
// Latency: LAYER_LATENCY+1 cycles from sync inputs to pins; layer inputs are registered once.
// Backpressure: none; one pixel per cycle. Optional VGA_BLINK_EN gates masked layers on frame_count[BLINK_BIT].
module vga_layer_compositor
    import vga_pkg::*;
#(
    parameter int                    NUM_LAYERS    = 2,
    parameter int                    LAYER_LATENCY = 1,
    parameter logic [7:0]            BG_COLOR      = COLOR_BG,
    parameter int                    FC_W          = 8,
    parameter logic [NUM_LAYERS-1:0] BLINK_MASK    = '0,
    parameter int                    BLINK_BIT     = 4
) (
    input  logic                      mclk,
    input  logic                      reset,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      von_in,
    input  logic [8*NUM_LAYERS-1:0]   layer_color,
    input  logic [NUM_LAYERS-1:0]     layer_valid,
    input  logic [NUM_LAYERS-1:0]     layer_enable,
    output logic                      HSYNC,
    output logic                      VSYNC,
    output logic [2:0]                OutRed,
    output logic [2:0]                OutGreen,
    output logic [2:0]                OutBlue,
    output logic                      frame_start,
    output logic [FC_W-1:0]           frame_count
);

    // ------------------------------------------------------------------
    // Sync / video-on delay line, matched to the layer pipeline
    // ------------------------------------------------------------------
    sync_t w_sync_in;
    sync_t w_sync_d;
    logic  w_d_hs;
    logic  w_d_vs;
    logic  w_d_von;

    assign w_sync_in = '{hs: hsync_in, vs: vsync_in, von: von_in};

    vga_delay_line #(
        .WIDTH     ($bits(sync_t)),
        .DEPTH     (LAYER_LATENCY),
        .RESET_VAL (SYNC_RESET)
    ) u_sync_dly (
        .i_clk   (mclk),
        .i_reset (reset),
        .i_dat   (w_sync_in),
        .o_dat   (w_sync_d)
    );

    assign w_d_hs  = w_sync_d.hs;
    assign w_d_vs  = w_sync_d.vs;
    assign w_d_von = w_sync_d.von;

    // ------------------------------------------------------------------
    // Frame boundary state
    // ------------------------------------------------------------------
    logic                  r_vs_q;
    logic [NUM_LAYERS-1:0] r_shadow_en;
    logic [FC_W-1:0]       r_frame_count;
    logic                  r_frame_start;
    logic                  w_frame_fall;

    // Boundary is the falling edge of the delayed vsync
    assign w_frame_fall = r_vs_q & ~w_d_vs;

    // ------------------------------------------------------------------
    // Blink gating
    // ------------------------------------------------------------------
    logic [NUM_LAYERS-1:0] w_blink_hide;

`ifdef VGA_BLINK_EN
    assign w_blink_hide = r_frame_count[BLINK_BIT] ? BLINK_MASK : '0;
`else
    // Blinking compiled out; the parameters stay for a uniform interface
    logic w_unused_blink;
    assign w_unused_blink = (^BLINK_MASK) ^ (BLINK_BIT != 0);
    assign w_blink_hide   = '0;
`endif

    // ------------------------------------------------------------------
    // Priority select: layer 0 wins, background if nothing claims the pixel
    // ------------------------------------------------------------------
    logic [NUM_LAYERS-1:0]       w_layer_hit;
    logic [NUM_LAYERS:0][7:0]    w_chain;
    rgb332_t                     w_color;

    assign w_layer_hit         = layer_valid & r_shadow_en & ~w_blink_hide;
    assign w_chain[NUM_LAYERS] = BG_COLOR;

    // Chain runs from the lowest priority (highest index) towards layer 0
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_prio
        assign w_chain[gi] = w_layer_hit[gi] ? layer_color[8*gi +: 8] : w_chain[gi+1];
    end

    assign w_color = w_d_von ? rgb332_t'(w_chain[0]) : COLOR_BLANK;

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic    r_hsync;
    logic    r_vsync;
    rgb332_t r_color;

    // Final pin stage: syncs and colour leave together
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_hsync <= HSYNC_IDLE;
            r_vsync <= VSYNC_IDLE;
            r_color <= COLOR_BLANK;
        end else begin
            r_hsync <= w_d_hs;
            r_vsync <= w_d_vs;
            r_color <= w_color;
        end
    end

    // Latch enables, count frames and pulse frame_start at each boundary
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_vs_q        <= VSYNC_IDLE;
            r_shadow_en   <= '1;
            r_frame_count <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_vs_q        <= w_d_vs;
            r_frame_start <= w_frame_fall;
            if (w_frame_fall) begin
                r_shadow_en   <= layer_enable;
                r_frame_count <= r_frame_count + FC_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pin mapping
    // ------------------------------------------------------------------
    logic [8:0] w_pins;

    assign w_pins      = rgb332_to_pins(r_color);
    assign HSYNC       = r_hsync;
    assign VSYNC       = r_vsync;
    assign OutRed      = w_pins[8:6];
    assign OutGreen    = w_pins[5:3];
    assign OutBlue     = w_pins[2:0];
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule
